// File: rtl/zx_sd_spi.sv
// zx_sd_spi -- SD-card SPI master for the ZX ULA CPLD.
//
// Provides a Z-Controller-compatible pair of I/O ports on the Z80 bus and
// drives the card pins in SPI mode 0, MSB first, one byte per trigger.
//
// Ports:
//   clk28    28 MHz system clock, all state on its rising edge
//   rst_n    asynchronous active-low reset
//   xa       CPU address A[7:0] (asynchronous to clk28)
//   xd_in    CPU write data
//   n_iorq   CPU IORQ, active low
//   n_rd     CPU RD, active low
//   n_wr     CPU WR, active low
//   n_m1     CPU M1, active low; IORQ together with M1 (INT ack) is never decoded
//   d_out    read data for the zx_ula data-bus mux
//   d_oe     d_out valid, zx_ula drives xd
//   sd_cd    card-detect switch, raw pin
//   sd_miso  card data out
//   sd_cs_n  card chip select, active low, owned entirely by software
//   sd_sck   SPI clock
//   sd_mosi  SPI data to card
//   busy     transfer in progress
//
// Parameters:
//   PORT_DATA  low address byte of the data port (read/write)
//   PORT_CTRL  low address byte of the control/status port
//   SCK_HALF   clk28 cycles per SCK half-period (>= 1)
`timescale 1ns/1ps
module zx_sd_spi #(
  parameter logic [7:0]  PORT_DATA = 8'h57,
  parameter logic [7:0]  PORT_CTRL = 8'h77,
  parameter int unsigned SCK_HALF  = 1
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic [7:0] xa,
  input  logic [7:0] xd_in,
  input  logic       n_iorq,
  input  logic       n_rd,
  input  logic       n_wr,
  input  logic       n_m1,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       sd_cd,
  input  logic       sd_miso,
  output logic       sd_cs_n,
  output logic       sd_sck,
  output logic       sd_mosi,
  output logic       busy
);

  localparam int unsigned     HW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [HW-1:0]   HALF_LAST = HW'(SCK_HALF - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;

  logic          io_wr_s;
  logic          io_rd_s;
  logic          wr_meta_r, wr_sync_r, wr_prev_r;
  logic          rd_meta_r, rd_sync_r, rd_prev_r;
  logic          rd_hit_r;
  logic          cd_meta_r, cd_sync_r;

  logic          wr_evt_s;
  logic          wr_data_s;
  logic          wr_ctrl_s;
  logic          rd_end_s;
  logic [7:0]    tx_sel_s;

  logic          load_s;
  logic          tog_s;
  logic          done_s;

  logic [HW-1:0] half_cnt_r;
  logic [3:0]    tog_cnt_r;
  logic [6:0]    tx_r;
  logic [7:0]    shift_r;
  logic [7:0]    rx_r;
  logic          sck_r;
  logic          mosi_r;
  logic          cs_n_r;

  // Raw bus strobes; M1 low marks an interrupt acknowledge, never an I/O access.
  assign io_wr_s = ~n_iorq & ~n_wr & n_m1;
  assign io_rd_s = ~n_iorq & ~n_rd & n_m1;

  // d_oe stays combinational so read data is on the bus for the whole CPU read.
  assign d_oe = io_rd_s & ((xa == PORT_DATA) | (xa == PORT_CTRL));

  // Strobe and card-detect synchronisers plus the latched read-address hit.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      wr_meta_r <= 1'b0;
      wr_sync_r <= 1'b0;
      wr_prev_r <= 1'b0;
      rd_meta_r <= 1'b0;
      rd_sync_r <= 1'b0;
      rd_prev_r <= 1'b0;
      rd_hit_r  <= 1'b0;
      cd_meta_r <= 1'b0;
      cd_sync_r <= 1'b0;
    end else begin
      wr_meta_r <= io_wr_s;
      wr_sync_r <= wr_meta_r;
      wr_prev_r <= wr_sync_r;
      rd_meta_r <= io_rd_s;
      rd_sync_r <= rd_meta_r;
      rd_prev_r <= rd_sync_r;
      cd_meta_r <= sd_cd;
      cd_sync_r <= cd_meta_r;
      // Address is captured only while the synced read is active, so the
      // read-end event still knows which port was read after xa moves on.
      if (rd_sync_r) begin
        rd_hit_r <= (xa == PORT_DATA);
      end else begin
        rd_hit_r <= rd_hit_r;
      end
    end
  end

  assign wr_evt_s  = wr_sync_r & ~wr_prev_r;
  assign wr_data_s = wr_evt_s & (xa == PORT_DATA);
  assign wr_ctrl_s = wr_evt_s & (xa == PORT_CTRL);
  assign rd_end_s  = ~rd_sync_r & rd_prev_r & rd_hit_r;

  // Transmit byte: CPU data for a port write, all ones for the read-ahead.
  always_comb begin
    tx_sel_s = 8'hFF;
    if (wr_data_s) begin
      tx_sel_s = xd_in;
    end else begin
      tx_sel_s = 8'hFF;
    end
  end

  // Read mux: status port reports busy and the synced card-detect.
  always_comb begin
    d_out = rx_r;
    if (xa == PORT_CTRL) begin
      d_out = {6'b000000, busy, cd_sync_r};
    end else begin
      d_out = rx_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state and datapath strobes; triggers are ignored unless idle.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    tog_s      = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wr_data_s | rd_end_s) begin
          state_nx_s = ST_SHIFT;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (half_cnt_r == HALF_LAST) begin
          tog_s = 1'b1;
          // The 16th toggle is the 8th falling edge: the byte is complete.
          if (tog_cnt_r == 4'd15) begin
            done_s     = 1'b1;
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else begin
          state_nx_s = ST_SHIFT;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Shift datapath: SCK generation, MOSI update on falls, MISO capture on rises.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_r <= '0;
      tog_cnt_r  <= 4'd0;
      tx_r       <= 7'h7F;
      shift_r    <= 8'hFF;
      rx_r       <= 8'hFF;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b1;
    end else if (load_s) begin
      half_cnt_r <= '0;
      tog_cnt_r  <= 4'd0;
      tx_r       <= tx_sel_s[6:0];
      sck_r      <= 1'b0;
      mosi_r     <= tx_sel_s[7];
    end else if (tog_s) begin
      half_cnt_r <= '0;
      tog_cnt_r  <= tog_cnt_r + 4'd1;
      sck_r      <= ~sck_r;
      if (!sck_r) begin
        shift_r <= {shift_r[6:0], sd_miso};
      end else if (done_s) begin
        rx_r      <= shift_r;
        mosi_r    <= 1'b1;
        tog_cnt_r <= 4'd0;
      end else begin
        mosi_r <= tx_r[6];
        tx_r   <= {tx_r[5:0], 1'b1};
      end
    end else if (state_r == ST_SHIFT) begin
      half_cnt_r <= half_cnt_r + HW'(1);
    end else begin
      half_cnt_r <= '0;
    end
  end

  // Chip select is written only by the CPU through the control port.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_r <= 1'b1;
    end else if (wr_ctrl_s) begin
      cs_n_r <= xd_in[1];
    end else begin
      cs_n_r <= cs_n_r;
    end
  end

  assign sd_cs_n = cs_n_r;
  assign sd_sck  = sck_r;
  assign sd_mosi = mosi_r;
  assign busy    = (state_r == ST_SHIFT);

endmodule

// File: tb/tb_zx_sd_spi.sv
`timescale 1ns/1ps
module tb_zx_sd_spi;

  logic       clk28  = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] xa     = 8'h00;
  logic [7:0] xd_in  = 8'h00;
  logic       n_iorq = 1'b1;
  logic       n_rd   = 1'b1;
  logic       n_wr   = 1'b1;
  logic       n_m1   = 1'b1;
  logic       sd_cd  = 1'b0;

  // Instance A: fast SCK at the default ports; instance B: slow SCK at 0x5B/0x7B.
  logic [7:0] d_out_a, d_out_b;
  logic       d_oe_a, d_oe_b;
  logic       cs_a, sck_a, mosi_a, busy_a, miso_a;
  logic       cs_b, sck_b, mosi_b, busy_b, miso_b;

  int n_checks = 0;
  int n_err    = 0;

  always #18 clk28 = ~clk28;

  zx_sd_spi #(.PORT_DATA(8'h57), .PORT_CTRL(8'h77), .SCK_HALF(1)) dut_a (
    .clk28(clk28), .rst_n(rst_n), .xa(xa), .xd_in(xd_in),
    .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1),
    .d_out(d_out_a), .d_oe(d_oe_a), .sd_cd(sd_cd), .sd_miso(miso_a),
    .sd_cs_n(cs_a), .sd_sck(sck_a), .sd_mosi(mosi_a), .busy(busy_a)
  );

  zx_sd_spi #(.PORT_DATA(8'h5B), .PORT_CTRL(8'h7B), .SCK_HALF(8)) dut_b (
    .clk28(clk28), .rst_n(rst_n), .xa(xa), .xd_in(xd_in),
    .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr), .n_m1(n_m1),
    .d_out(d_out_b), .d_oe(d_oe_b), .sd_cd(sd_cd), .sd_miso(miso_b),
    .sd_cs_n(cs_b), .sd_sck(sck_b), .sd_mosi(mosi_b), .busy(busy_b)
  );

  // Card models: present reply MSB first, advance on SCK fall, record MOSI on SCK rise.
  logic [7:0] reply_a = 8'hFF;
  logic [7:0] reply_b = 8'hFF;
  logic [2:0] cbit_a  = 3'd0;
  logic [2:0] cbit_b  = 3'd0;
  logic [7:0] got_a   = 8'h00;
  logic [7:0] got_b   = 8'h00;
  int         rises_a = 0;
  int         rises_b = 0;

  assign miso_a = reply_a[3'd7 - cbit_a];
  assign miso_b = reply_b[3'd7 - cbit_b];

  always @(negedge sck_a or negedge rst_n)
    if (!rst_n) cbit_a <= 3'd0;
    else        cbit_a <= cbit_a + 3'd1;

  always @(negedge sck_b or negedge rst_n)
    if (!rst_n) cbit_b <= 3'd0;
    else        cbit_b <= cbit_b + 3'd1;

  always @(posedge sck_a) begin
    got_a   <= {got_a[6:0], mosi_a};
    rises_a <= rises_a + 1;
  end

  always @(posedge sck_b) begin
    got_b   <= {got_b[6:0], mosi_b};
    rises_b <= rises_b + 1;
  end

  // Scoreboard: expected read data and expected MOSI bytes for instance A.
  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t       sb_q[$];
  logic [7:0] mosi_q[$];

  logic       sel_b_s;
  logic [7:0] d_out_sel;
  logic       d_oe_sel;
  assign sel_b_s   = (xa == 8'h5B) || (xa == 8'h7B);
  assign d_out_sel = sel_b_s ? d_out_b : d_out_a;
  assign d_oe_sel  = sel_b_s ? d_oe_b  : d_oe_a;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    n_checks++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(negedge clk28);
  endtask

  task automatic sb_pop_check(logic [7:0] obs);
    exp_t e;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_err++;
      $error("FAIL sb_underflow: observed=%02h expected=<queued value>", obs);
    end
    if (sb_q.size() != 0) begin
      n_checks--;
      e = sb_q.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic cpu_read(logic [7:0] addr, string tag, logic [7:0] exp);
    sb_q.push_back('{tag, exp});
    @(negedge clk28);
    xa = addr; n_m1 = 1'b1; n_iorq = 1'b0; n_rd = 1'b0;
    clks(4);
    chk({tag, "_oe"}, {7'd0, d_oe_sel}, 8'h01);
    sb_pop_check(d_out_sel);
    n_iorq = 1'b1; n_rd = 1'b1;
    clks(4);
  endtask

  task automatic cpu_write(logic [7:0] addr, logic [7:0] data);
    @(negedge clk28);
    xa = addr; xd_in = data; n_m1 = 1'b1; n_iorq = 1'b0; n_wr = 1'b0;
    clks(4);
    n_iorq = 1'b1; n_wr = 1'b1;
    clks(3);
  endtask

  task automatic wait_busy(logic use_b, logic lvl, int budget, string tag);
    int n = 0;
    while (((use_b ? busy_b : busy_a) !== lvl) && (n < budget)) begin
      @(negedge clk28);
      n++;
    end
    chk(tag, {7'd0, (use_b ? busy_b : busy_a)}, {7'd0, lvl});
  endtask

  // Compare the byte the card saw on MOSI against the next queued transmit byte.
  task automatic chk_mosi(string tag);
    logic [7:0] e;
    n_checks++;
    assert (mosi_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s_underflow: observed=%02h expected=<queued byte>", tag, got_a);
    end
    if (mosi_q.size() != 0) begin
      n_checks--;
      e = mosi_q.pop_front();
      for (int i = 7; i >= 0; i--) begin
        chk($sformatf("%s_bit%0d", tag, i), {7'd0, got_a[i]}, {7'd0, e[i]});
      end
    end
  endtask

  task automatic finish_a(string tag);
    chk({tag, "_started"}, {7'd0, busy_a}, 8'h01);
    wait_busy(1'b0, 1'b0, 60, {tag, "_done"});
    chk_mosi({tag, "_mosi"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r0;
    int len;

    // Reset values.
    clks(3);
    chk("rst_cs_n", {7'd0, cs_a},   8'h01);
    chk("rst_sck",  {7'd0, sck_a},  8'h00);
    chk("rst_mosi", {7'd0, mosi_a}, 8'h01);
    chk("rst_busy", {7'd0, busy_a}, 8'h00);
    rst_n = 1'b1;
    clks(3);

    // First data read returns the reset rx value and reads ahead with 0xFF.
    reply_a = 8'h81;
    mosi_q.push_back(8'hFF);
    cpu_read(8'h57, "rd_after_rst", 8'hFF);
    finish_a("ff_first");

    // Chip select via the control port.
    @(negedge clk28);
    xa = 8'h77; xd_in = 8'h00; n_iorq = 1'b0; n_wr = 1'b0;
    n = 0;
    while ((cs_a !== 1'b0) && (n < 4)) begin
      @(negedge clk28);
      n++;
    end
    chk("cs_low_4clk", {7'd0, cs_a}, 8'h00);
    n_iorq = 1'b1; n_wr = 1'b1;
    clks(3);
    cpu_write(8'h77, 8'h02);
    chk("cs_high", {7'd0, cs_a}, 8'h01);
    cpu_write(8'h77, 8'hFD);
    chk("cs_other_bits", {7'd0, cs_a}, 8'h00);
    cpu_read(8'h77, "rd_ctrl_idle", 8'h00);

    // Main transfer: 0xA5 out, card answers 0x3C, busy exactly 16 clk28.
    reply_a = 8'h3C;
    mosi_q.push_back(8'hA5);
    @(negedge clk28);
    xa = 8'h57; xd_in = 8'hA5; n_iorq = 1'b0; n_wr = 1'b0;
    wait_busy(1'b0, 1'b1, 8, "a5_start");
    len = 0;
    while ((busy_a === 1'b1) && (len < 40)) begin
      @(negedge clk28);
      len++;
    end
    chk_int("a5_busy_len", len, 16);
    n_iorq = 1'b1; n_wr = 1'b1;
    clks(3);
    chk_mosi("a5_mosi");
    chk_int("a5_rises", rises_a, 16);

    // Reading rx fires a 0xFF read-ahead; the next read returns its reply.
    reply_a = 8'h5E;
    mosi_q.push_back(8'hFF);
    cpu_read(8'h57, "rd_3c", 8'h3C);
    finish_a("ff_after_3c");
    reply_a = 8'hC7;
    mosi_q.push_back(8'hFF);
    cpu_read(8'h57, "rd_5e", 8'h5E);
    finish_a("ff_after_5e");

    // Slow instance: second write while busy is ignored.
    sd_cd   = 1'b1;
    reply_b = 8'h96;
    r0      = rises_b;
    cpu_write(8'h5B, 8'h4D);
    chk("b_busy_1st", {7'd0, busy_b}, 8'h01);
    cpu_write(8'h5B, 8'h11);
    cpu_read(8'h7B, "rd_ctrl_busy", 8'h03);
    wait_busy(1'b1, 1'b0, 200, "b_done");
    clks(2);
    chk_int("b_sck_pulses", rises_b - r0, 8);
    chk("b_mosi_first", got_b, 8'h4D);
    chk("b_busy_idle", {7'd0, busy_b}, 8'h00);
    cpu_read(8'h5B, "rd_b_first", 8'h96);
    wait_busy(1'b1, 1'b0, 200, "b_ff_done");
    chk("b_mosi_ff", got_b, 8'hFF);

    // Asynchronous reset in the middle of a slow transfer.
    reply_b = 8'h00;
    r0      = rises_b;
    cpu_write(8'h5B, 8'h00);
    n = 0;
    while ((rises_b - r0 < 3) && (n < 200)) begin
      @(negedge clk28);
      n++;
    end
    chk_int("b_three_pulses", rises_b - r0, 3);
    clks(3);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_sck",  {7'd0, sck_b},  8'h00);
    chk("arst_mosi", {7'd0, mosi_b}, 8'h01);
    chk("arst_busy", {7'd0, busy_b}, 8'h00);
    chk("arst_cs_n", {7'd0, cs_a},   8'h01);
    clks(2);
    rst_n = 1'b1;
    clks(3);
    cpu_read(8'h5B, "rd_b_after_arst", 8'hFF);
    wait_busy(1'b1, 1'b0, 200, "b_ff2_done");

    // Interrupt acknowledge at the data address must not decode.
    r0 = rises_a;
    @(negedge clk28);
    xa = 8'h57; n_m1 = 1'b0; n_iorq = 1'b0; n_rd = 1'b0;
    clks(2);
    chk("intack_oe", {7'd0, d_oe_a}, 8'h00);
    clks(2);
    n_rd = 1'b1; xd_in = 8'h42; n_wr = 1'b0;
    clks(4);
    n_wr = 1'b1; n_iorq = 1'b1; n_m1 = 1'b1;
    clks(8);
    chk("intack_busy", {7'd0, busy_a}, 8'h00);
    chk_int("intack_pulses", rises_a - r0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
